modn_seq: RTL and testbench

- Sequential modular-reduction unit; computes x = a mod b by restoring shift-subtract, one dividend bit per clock.
- Responder side of the modn handshake (rst / en / a / b -> ready / x) driven by the RSA exponentiation controller.
- One instance sits beside the controller's modn port group.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/modn_seq_if.sv | 20 ++
 rtl/modn_seq_sub_step.sv | 28 ++
 rtl/modn_seq.sv | 89 ++++++++
 tb/tb_modn_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: constants shared by the RSA datapath blocks.
//   DATA_WIDTH / DATA_DOUBLE_WIDTH : modulus and product widths
//   CNT_WIDTH                      : width of the per-bit step counter
//   MODN_*                         : modn_seq state encodings
//   MODN_B_ZERO_SENTINEL           : result reported for a zero modulus
package rsa_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int DATA_DOUBLE_WIDTH = 16;
    localparam int CNT_WIDTH         = $clog2(DATA_DOUBLE_WIDTH);

    localparam logic [1:0] MODN_IDLE = 2'd0;
    localparam logic [1:0] MODN_CALC = 2'd1;
    localparam logic [1:0] MODN_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] MODN_B_ZERO_SENTINEL = {DATA_WIDTH{1'b1}};

endpackage

// File: rtl/modn_seq_if.sv
// modn_if: modn handshake between the RSA controller and the reduction unit.
//   rst   : synchronous soft clear (controller -> unit)
//   en    : start request          (controller -> unit)
//   a, b  : dividend and modulus   (controller -> unit)
//   x     : registered remainder   (unit -> controller)
//   ready : result valid           (unit -> controller)
interface modn_if;
    import rsa_pkg::*;

    logic                         rst;
    logic                         en;
    logic [DATA_DOUBLE_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0]        b;
    logic [DATA_WIDTH-1:0]        x;
    logic                         ready;

    modport master (output rst, en, a, b, input x, ready);
    modport slave  (input rst, en, a, b, output x, ready);

endinterface

// File: rtl/modn_seq_sub_step.sv
// modn_sub_step: one restoring shift-subtract step of a mod b.
//   r      : current partial remainder (always < b)
//   bit_in : next dividend bit, MSB first
//   b      : modulus
//   r_next : partial remainder after shifting in bit_in and reducing
module modn_sub_step
    import rsa_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] r,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] r_next
);

    // One extra bit: 2*r+1 can exceed the DATA_WIDTH range before reduction.
    logic [DATA_WIDTH:0] r_shift;

    always_comb begin
        r_shift = {r, bit_in};
        if (r_shift >= {1'b0, b}) begin
            // Difference is < b, so the top bit is always zero and is dropped.
            r_next = DATA_WIDTH'(r_shift - {1'b0, b});
        end else begin
            r_next = r_shift[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/modn_seq.sv
// modn_seq: sequential x = a mod b, one dividend bit per clock.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : modn_if.slave (rst, en, a, b -> x, ready)
// Optional macro MODN_EARLY_EXIT_EN: when a < b the result is a itself and is
// returned on the start edge instead of after the full bit-serial pass.
//
// state | meaning
// IDLE  | waiting for en; ready low
// CALC  | shifting one dividend bit per clock into the remainder
// DONE  | x and ready held until rst or reset_n
module modn_seq
    import rsa_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    modn_if.slave bus
);

    logic [1:0]                   state;
    logic [DATA_WIDTH-1:0]        r;
    logic [DATA_WIDTH-1:0]        r_next;
    logic [DATA_DOUBLE_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0]        modulus;
    logic [CNT_WIDTH-1:0]         cnt;

    modn_sub_step u_sub_step (
        .r      (r),
        .bit_in (shift[DATA_DOUBLE_WIDTH-1]),
        .b      (modulus),
        .r_next (r_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= MODN_IDLE;
            bus.ready <= 1'b0;
            bus.x     <= '0;
            r         <= '0;
            shift     <= '0;
            modulus   <= '0;
            cnt       <= '0;
        end else if (bus.rst) begin
            // x deliberately keeps its last value.
            state     <= MODN_IDLE;
            bus.ready <= 1'b0;
        end else begin
            case (state)
                MODN_IDLE: begin
                    if (bus.en) begin
                        shift   <= bus.a;
                        modulus <= bus.b;
                        r       <= '0;
                        cnt     <= CNT_WIDTH'(DATA_DOUBLE_WIDTH - 1);
                        if (bus.b == '0) begin
                            bus.x     <= MODN_B_ZERO_SENTINEL;
                            bus.ready <= 1'b1;
                            state     <= MODN_DONE;
`ifdef MODN_EARLY_EXIT_EN
                        end else if (bus.a < {{DATA_WIDTH{1'b0}}, bus.b}) begin
                            bus.x     <= bus.a[DATA_WIDTH-1:0];
                            bus.ready <= 1'b1;
                            state     <= MODN_DONE;
`endif
                        end else begin
                            state <= MODN_CALC;
                        end
                    end
                end
                MODN_CALC: begin
                    r     <= r_next;
                    shift <= shift << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bus.x     <= r_next;
                        bus.ready <= 1'b1;
                        state     <= MODN_DONE;
                    end
                end
                MODN_DONE: begin
                end
                default: begin
                    state <= MODN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modn_seq.sv
module tb_modn_seq;
    import rsa_pkg::*;

`ifdef MODN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clock;
    logic reset_n;
    modn_if bus();

    modn_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a request yields a % b (or the sentinel)
    // after a fixed latency; rst discards everything except the last x.
    int       m_phase;   // 0 idle, 1 busy, 2 holding result
    int       m_left;
    int       m_res;
    logic     m_ready;
    logic [7:0] m_x;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_ready = 1'b0; m_x = 8'd0;
        end else if (bus.rst) begin
            m_phase = 0; m_ready = 1'b0;
        end else if (m_phase == 0 && bus.en) begin
            if (bus.b == 8'd0) begin
                m_x = 8'hFF; m_ready = 1'b1; m_phase = 2;
            end else if (EARLY && int'(bus.a) < int'(bus.b)) begin
                m_x = bus.a[7:0]; m_ready = 1'b1; m_phase = 2;
            end else begin
                m_res = int'(bus.a) % int'(bus.b);
                m_left = 16; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_x = 8'(m_res); m_ready = 1'b1; m_phase = 2;
            end
        end
    end

    always @(negedge clock) begin
        check("ready_vs_model", int'(bus.ready), int'(m_ready));
        check("x_vs_model", int'(bus.x), int'(m_x));
    end

    task automatic do_rst();
        @(posedge clock); #1;
        bus.rst = 1'b1; bus.en = 1'b0;
        @(posedge clock); #1;
        check("ready_after_rst", int'(bus.ready), 0);
        bus.rst = 1'b0;
    endtask

    // Start a request, then count edges until ready; optionally scramble
    // the inputs while busy to show they are ignored.
    task automatic run(input logic [15:0] a, input logic [7:0] b, input int exp_x,
                       input int exp_lat, input bit scramble, input string name);
        int n;
        @(posedge clock); #1;
        bus.a = a; bus.b = b; bus.en = 1'b1;
        @(posedge clock); #1;
        bus.en = 1'b0;
        n = 0;
        while (!bus.ready && n < 40) begin
            if (scramble) begin
                bus.a  = 16'($urandom);
                bus.b  = 8'($urandom);
                bus.en = 1'($urandom);
            end
            @(posedge clock); #1;
            n++;
        end
        bus.en = 1'b0;
        check({name, "_latency"}, n, exp_lat);
        check({name, "_x"}, int'(bus.x), exp_x);
    endtask

    function automatic int lat_for(input int a, input int b);
        if (b == 0) return 0;
        if (EARLY && a < b) return 0;
        return 16;
    endfunction

    initial begin
        reset_n = 1'b0;
        bus.rst = 1'b0; bus.en = 1'b0; bus.a = '0; bus.b = '0;
        #2;
        check("reset_ready", int'(bus.ready), 0);
        check("reset_x", int'(bus.x), 0);
        #10 reset_n = 1'b1;

        // Hand-computed directed cases.
        do_rst();
        run(16'd1000, 8'd7, 6, 16, 1'b0, "d1000_7");
        for (int i = 0; i < 10; i++) begin
            bus.en = ~bus.en;
            @(posedge clock); #1;
            check("hold_ready", int'(bus.ready), 1);
            check("hold_x", int'(bus.x), 6);
        end
        bus.en = 1'b0;
        do_rst();
        run(16'hFFFF, 8'hFF, 0, 16, 1'b0, "dFFFF_FF");
        do_rst();
        run(16'hFFFF, 8'd1, 0, 16, 1'b0, "dFFFF_1");
        do_rst();
        run(16'd300, 8'd255, 45, 16, 1'b0, "d300_255");
        do_rst();
        run(16'd3, 8'd5, 3, EARLY ? 0 : 16, 1'b0, "d3_5");
        do_rst();
        run(16'd1234, 8'd0, 255, 0, 1'b0, "b_zero");

        // Abort mid-CALC, then a fresh request.
        do_rst();
        @(posedge clock); #1;
        bus.a = 16'd1000; bus.b = 8'd7; bus.en = 1'b1;
        @(posedge clock); #1;
        bus.en = 1'b0;
        repeat (5) @(posedge clock);
        #1 bus.rst = 1'b1;
        @(posedge clock); #1;
        bus.rst = 1'b0;
        check("abort_ready", int'(bus.ready), 0);
        repeat (20) @(posedge clock);
        #1 check("abort_stays_idle", int'(bus.ready), 0);
        run(16'd100, 8'd9, 1, 16, 1'b0, "after_abort");

        // en together with rst must not start anything.
        @(posedge clock); #1;
        bus.rst = 1'b1; bus.en = 1'b1; bus.a = 16'd5; bus.b = 8'd0;
        @(posedge clock); #1;
        bus.rst = 1'b0; bus.en = 1'b0;
        check("en_with_rst_ready", int'(bus.ready), 0);
        @(posedge clock); #1;
        check("en_with_rst_idle", int'(bus.ready), 0);

        // Async reset mid-CALC, between edges.
        run(16'd1000, 8'd7, 6, 16, 1'b0, "pre_async");
        do_rst();
        @(posedge clock); #1;
        bus.a = 16'd1000; bus.b = 8'd7; bus.en = 1'b1;
        @(posedge clock); #1;
        bus.en = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("async_ready", int'(bus.ready), 0);
        check("async_x", int'(bus.x), 0);
        #3 reset_n = 1'b1;
        run(16'd1000, 8'd7, 6, 16, 1'b0, "post_async");

        // Randomized requests with inputs scrambled during CALC.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            int ex;
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 8'd0;
                1: begin rb = 8'($urandom_range(1, 255)); ra = 16'($urandom_range(0, 300)); end
                default: rb = 8'($urandom);
            endcase
            ex = (rb == 8'd0) ? 255 : int'(ra) % int'(rb);
            do_rst();
            run(ra, rb, ex, lat_for(int'(ra), int'(rb)), 1'b1, "rand");
        end

        @(posedge clock); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
